// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle between the arbiter (master) and the memory (slave).
// Command fields are held stable by the master while mem_req is high.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with fetch-kill support.
// Define MEM_ARB_STARVE_GUARD_EN to compile in the data-streak starvation guard for fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_kill,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    mem_port_arbiter_if.master    mem,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  dm_valid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              kill_flag;
    logic              override;
    logic              grant_if;
    logic              grant_dm;

    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [STRB_W-1:0] mem_wstrb_nxt;
    logic              if_valid_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic              dm_valid_nxt;
    logic [DATA_W-1:0] dm_rdata_nxt;
    logic              kill_nxt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    logic [STREAK_W-1:0] streak_cnt;

    assign override = if_req && (streak_cnt == STREAK_W'(MAX_DATA_STREAK));

    // Counts data grants that a pending fetch has lost; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_cnt <= '0;
        end else if (!if_req || grant_if) begin
            streak_cnt <= '0;
        end else if (grant_dm && (streak_cnt != STREAK_W'(MAX_DATA_STREAK))) begin
            streak_cnt <= streak_cnt + STREAK_W'(1);
        end
    end
`else
    assign override = 1'b0;
`endif

    // Raw dm_req keeps priority even in its valid cycle, so a stale data request
    // blocks fetch for that cycle rather than letting fetch slip in.
    assign grant_if = (state == IDLE) && if_req && !if_valid && (!dm_req || override);
    assign grant_dm = (state == IDLE) && dm_req && !dm_valid && !override;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_nxt = BUSY_IF;
                end else if (grant_dm) begin
                    state_nxt = BUSY_DM;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem.mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_nxt   = mem.mem_req;
        mem_we_nxt    = mem.mem_we;
        mem_addr_nxt  = mem.mem_addr;
        mem_wdata_nxt = mem.mem_wdata;
        mem_wstrb_nxt = mem.mem_wstrb;
        if_valid_nxt  = 1'b0;
        if_rdata_nxt  = if_rdata;
        dm_valid_nxt  = 1'b0;
        dm_rdata_nxt  = dm_rdata;
        kill_nxt      = kill_flag;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    mem_wstrb_nxt = '0;
                    kill_nxt      = if_kill;
                end else if (grant_dm) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    mem_wstrb_nxt = dm_wstrb;
                end
            end
            BUSY_IF: begin
                if (mem.mem_ready) begin
                    mem_req_nxt = 1'b0;
                    kill_nxt    = 1'b0;
                    // A killed fetch still drains from the port but is never delivered.
                    if (!kill_flag && !if_kill) begin
                        if_valid_nxt = 1'b1;
                        if_rdata_nxt = mem.mem_rdata;
                    end
                end else begin
                    kill_nxt = kill_flag | if_kill;
                end
            end
            BUSY_DM: begin
                if (mem.mem_ready) begin
                    mem_req_nxt  = 1'b0;
                    dm_valid_nxt = 1'b1;
                    dm_rdata_nxt = mem.mem_we ? '0 : mem.mem_rdata;
                end
            end
            default: begin
                mem_req_nxt = 1'b0;
                kill_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            if_valid      <= 1'b0;
            if_rdata      <= '0;
            dm_valid      <= 1'b0;
            dm_rdata      <= '0;
            kill_flag     <= 1'b0;
        end else begin
            mem.mem_req   <= mem_req_nxt;
            mem.mem_we    <= mem_we_nxt;
            mem.mem_addr  <= mem_addr_nxt;
            mem.mem_wdata <= mem_wdata_nxt;
            mem.mem_wstrb <= mem_wstrb_nxt;
            if_valid      <= if_valid_nxt;
            if_rdata      <= if_rdata_nxt;
            dm_valid      <= dm_valid_nxt;
            dm_rdata      <= dm_rdata_nxt;
            kill_flag     <= kill_nxt;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the instruction-fetch requester (IF) and the load/store requester (MEM stage) of the 5-stage RV32 pipeline. Issues one transaction at a time over a variable-latency req/ready port and returns read data to the winning requester. Drives per-requester stall signals that the pipeline control merges with its load-use and redirect logic. Drops a fetch response that a taken-branch redirect has killed.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobes are DATA_W/8
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending (starvation guard only)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  redirect pulse (modify_pc_ex); discards the fetch in flight
- dm_req  in  1  data request; held with all dm_* inputs until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  store byte enables
- mem_req  out  1  port request; held until mem_ready
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  port command; stable while mem_req
- mem_ready  in  1  port accepts and completes the transaction this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_valid  out  1  one-cycle pulse; load data valid or store completed
- dm_rdata  out  DATA_W  load data (0 for a store)
- stall_if  out  1  = if_req & ~if_valid
- stall_mem  out  1  = dm_req & ~dm_valid

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration, one grant per idle cycle:
  - Data wins over fetch by default.
  - Fetch wins when streak_cnt == MAX_DATA_STREAK and if_req is high.
- On grant, the command is registered into mem_* and the FSM moves to BUSY_IF or BUSY_DM. mem_req rises the next cycle.
- In BUSY_x, mem_req stays high with the command unchanged until mem_ready. On the mem_ready edge:
  - mem_req falls.
  - mem_rdata is captured into x_rdata.
  - x_valid pulses the next cycle.
  - The FSM returns to IDLE.
- Requests sampled in IDLE are ignored when the requester's valid pulse is high in the same cycle. This makes the requester's req drop effective before re-arbitration.
- streak_cnt (width $clog2(MAX_DATA_STREAK+1)):
  - +1 on a data grant while if_req is high, saturating.
  - Cleared on a fetch grant or whenever if_req is low.
- Kill handling:
  - if_kill in BUSY_IF, or in the cycle the fetch grant is issued, sets a kill flag.
  - The port transaction still completes; if_valid stays 0 for it and if_rdata holds its old value.
  - The flag clears on completion.
  - if_kill in IDLE or BUSY_DM has no effect.
  - A kill coincident with mem_ready still suppresses if_valid.
- Stores: dm_rdata = 0 on completion.
- Reset values:
  - FSM = IDLE.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
  - if_valid = 0, dm_valid = 0, if_rdata = 0, dm_rdata = 0.
  - streak_cnt = 0, kill flag = 0.
- Reset mid-transaction abandons the transaction: mem_req is 0 the following cycle and no valid pulse is ever produced for it.

## Timing
- Minimum latency: req seen in IDLE at cycle N, mem_req at N+1, mem_ready at N+1, x_valid at N+2.
- Each wait-state cycle (mem_ready low) adds one cycle.
- Back-to-back: the next grant can occur in cycle N+2 (the IDLE cycle), so the next mem_req is at N+3. Peak throughput is one transaction per 2 cycles.
- stall_if and stall_mem are combinational from registered valids and the req inputs. There is no combinational path from mem_ready to any output.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: streak_cnt and the MAX_DATA_STREAK fetch override are compiled in.
- Undefined: strict data priority; streak_cnt is absent and MAX_DATA_STREAK is unused.

## Test plan
- Reset with rst_n=0 for 2 cycles while if_req=1 -> all outputs 0, mem_req first rises 1 cycle after rst_n=1.
- Fetch 0x100, mem_ready delayed 2 cycles, mem_rdata=0x00500093 -> mem_addr=0x100 held 3 cycles, if_valid pulse with if_rdata=0x00500093, stall_if high until that pulse.
- if_req and dm_req (load 0x2000) in the same IDLE cycle -> data issued first, fetch issued after dm_valid, stall_if high throughout.
- Guard enabled, MAX_DATA_STREAK=2, continuous dm_req with if_req pending -> grant order DM, DM, IF, DM, DM, IF. Guard disabled -> IF never granted.
- if_kill pulse while BUSY_IF -> transaction completes on the port, no if_valid, the next fetch proceeds normally.
- Store 0x2004 with wdata=0xDEADBEEF, wstrb=4'b0011 -> port shows mem_we=1 with those values, dm_valid pulse with dm_rdata=0. rst_n=0 during BUSY_DM -> no dm_valid, mem_req=0 the next cycle.
